// File: rtl/quant_tile_sequencer.sv
// Per-tile controller for the per-channel quantizer: loads CHANNELS scale/zero-point LUT
// entries from parameter SRAM, then opens the accumulator stream for beats_per_tile beats.
module quant_tile_sequencer #(
  parameter int CHANNELS = 16,
  parameter int PARAM_AW = 10,
  parameter int TILE_W   = 16,
  parameter int BEAT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [TILE_W-1:0]   cfg_num_tiles_i,
  input  logic [BEAT_W-1:0]   cfg_beats_per_tile_i,
  input  logic [PARAM_AW-1:0] cfg_param_base_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_last_o,
  output logic                param_rd_en_o,
  output logic [PARAM_AW-1:0] param_rd_addr_o,
  input  logic [23:0]         param_rd_data_i,
  output logic                q_cfg_wr_en_o,
  output logic [5:0]          q_cfg_addr_o,
  output logic [63:0]         q_cfg_wdata_o,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                s_last_i,
  output logic                q_in_valid_o,
  input  logic                q_in_ready_i,
  output logic                q_in_last_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WLAST  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CH = 4'(CHANNELS - 1);

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [3:0]          chan_q, chan_d;
  logic [TILE_W-1:0]   num_tiles_q, num_tiles_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [PARAM_AW-1:0] base_q, base_d;
  logic                err_q, err_d;
  logic                wr_en_q;
  logic [3:0]          wr_chan_q;

  logic                streaming;
  logic                fire;
  logic                last_beat;
  logic                tiles_left;
  logic [PARAM_AW-1:0] tile_off;

  // Stream handshake: a beat transfers on a cycle where valid && ready are both high.
  // The sequencer never buffers data; it only gates valid/ready and forces last.
  assign streaming    = (state_q == S_STREAM);
  assign q_in_valid_o = streaming && s_valid_i;
  assign s_ready_o    = streaming && q_in_ready_i;
  assign fire         = q_in_valid_o && q_in_ready_i;
  assign last_beat    = (beat_q == beats_q - BEAT_W'(1));
  assign q_in_last_o  = streaming && last_beat;
  assign tiles_left   = ((tile_q + TILE_W'(1)) != num_tiles_q);

  // SRAM address wraps modulo 2^PARAM_AW by truncation.
  assign tile_off        = PARAM_AW'(tile_q) * PARAM_AW'(CHANNELS);
  assign param_rd_en_o   = (state_q == S_LOAD);
  assign param_rd_addr_o = param_rd_en_o ? (base_q + tile_off + PARAM_AW'(chan_q)) : '0;

  assign q_cfg_wr_en_o = wr_en_q;
  assign q_cfg_addr_o  = wr_en_q ? {2'b01, wr_chan_q} : 6'd0;
  assign q_cfg_wdata_o = wr_en_q ? {40'd0, param_rd_data_i} : 64'd0;

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_last_o = err_q;
  assign state_o    = state_q;

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    beat_d      = beat_q;
    chan_d      = chan_q;
    num_tiles_d = num_tiles_q;
    beats_d     = beats_q;
    base_d      = base_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_tiles_d = cfg_num_tiles_i;
          beats_d     = cfg_beats_per_tile_i;
          base_d      = cfg_param_base_i;
          err_d       = 1'b0;
          tile_d      = '0;
          beat_d      = '0;
          chan_d      = '0;
          state_d     = (cfg_num_tiles_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        chan_d = chan_q + 4'd1;
        if (chan_q == LAST_CH) begin
          chan_d  = '0;
          state_d = S_WLAST;
        end
      end
      S_WLAST: begin
        if (beats_q == '0) begin
          tile_d  = tile_q + TILE_W'(1);
          state_d = tiles_left ? S_LOAD : S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (fire) begin
          if (s_last_i != last_beat) err_d = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            tile_d  = tile_q + TILE_W'(1);
            state_d = tiles_left ? S_LOAD : S_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tile_q      <= '0;
      beat_q      <= '0;
      chan_q      <= '0;
      num_tiles_q <= '0;
      beats_q     <= '0;
      base_q      <= '0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_chan_q   <= '0;
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      beat_q      <= beat_d;
      chan_q      <= chan_d;
      num_tiles_q <= num_tiles_d;
      beats_q     <= beats_d;
      base_q      <= base_d;
      err_q       <= err_d;
      // LUT write trails the SRAM read by its one-cycle latency.
      wr_en_q     <= param_rd_en_o;
      wr_chan_q   <= chan_q;
    end
  end

endmodule
